restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 33 +++
 rtl/restoring_divider_cra.sv | 41 ++++
 rtl/restoring_divider.sv | 177 +++++++++++++++++
 tb/tb_restoring_divider.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// ---------------------------------------------------------------------------
// restoring_divider_pkg
//
// Purpose:
//   Shared definitions for the restoring divider slice: the controller state
//   enumeration, the default operand width and a helper that sizes the
//   step counter so it can hold every value from 0 up to the operand width.
//
// Contents:
//   div_state_e           - IDLE / CALC / DONE controller states
//   DIV_BIT_NUMB_DEFAULT  - default operand and result width
//   step_cnt_width()      - clog2(bit_numb + 1), width of the step counter
// ---------------------------------------------------------------------------
package restoring_divider_pkg;

    // Controller states. IDLE waits for a request, CALC runs one restoring
    // step per cycle, DONE presents the one-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Default width of the dividend, divisor, quotient and remainder.
    localparam int DIV_BIT_NUMB_DEFAULT = 4;

    // Width of the step counter. Sized for bit_numb + 1 values so the
    // counter is never narrower than the number of steps it tracks.
    function automatic int step_cnt_width(input int bit_numb);
        return $clog2(bit_numb + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_cra.sv
// ---------------------------------------------------------------------------
// carry_ripple_adder
//
// Purpose:
//   Plain ripple-carry adder built from a chain of full adders. The divider
//   uses it to form the trial subtraction of each restoring step.
//
// Ports:
//   a_i      [CRA_BIT_NUMB-1:0]  first addend
//   b_i      [CRA_BIT_NUMB-1:0]  second addend
//   carry_i                      carry into bit 0
//   sum_o    [CRA_BIT_NUMB-1:0]  sum bits
//   carry_o                      carry out of the most significant bit
// ---------------------------------------------------------------------------
module carry_ripple_adder
    import restoring_divider_pkg::*;
#(
    parameter int CRA_BIT_NUMB = DIV_BIT_NUMB_DEFAULT + 1
) (
    input  logic [CRA_BIT_NUMB-1:0] a_i,
    input  logic [CRA_BIT_NUMB-1:0] b_i,
    input  logic                    carry_i,
    output logic [CRA_BIT_NUMB-1:0] sum_o,
    output logic                    carry_o
);

    // Carry chain: carry[i] enters bit i, carry[CRA_BIT_NUMB] leaves the top.
    logic [CRA_BIT_NUMB:0] carry;

    assign carry[0] = carry_i;

    // One full adder per bit; generate and propagate terms feed the next
    // stage so the carry ripples from LSB to MSB.
    for (genvar i = 0; i < CRA_BIT_NUMB; i++) begin : g_full_adder
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign carry_o = carry[CRA_BIT_NUMB];

endmodule

// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//
// Purpose:
//   Sequential unsigned restoring divider. A request accepted in IDLE
//   latches both operands; the quotient is built one bit per CALC cycle,
//   MSB first, and DONE presents a one-cycle completion pulse. A zero
//   divisor skips CALC and reports quotient = all ones, remainder =
//   dividend with div_by_zero_o set.
//
// Ports:
//   clk_i                          clock, rising edge active
//   rst_ni                         asynchronous reset, active low
//   start_i                        division request, honoured only in IDLE
//   dividend_i    [DIV_BIT_NUMB]   unsigned dividend, sampled on acceptance
//   divisor_i     [DIV_BIT_NUMB]   unsigned divisor, sampled on acceptance
//   busy_o                         high whenever the controller is not IDLE
//   done_o                         one-cycle pulse while in DONE
//   quotient_o    [DIV_BIT_NUMB]   unsigned quotient
//   remainder_o   [DIV_BIT_NUMB]   unsigned remainder
//   div_by_zero_o                  set with the results for a zero divisor
// ---------------------------------------------------------------------------
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int DIV_BIT_NUMB = DIV_BIT_NUMB_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [DIV_BIT_NUMB-1:0] dividend_i,
    input  logic [DIV_BIT_NUMB-1:0] divisor_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DIV_BIT_NUMB-1:0] quotient_o,
    output logic [DIV_BIT_NUMB-1:0] remainder_o,
    output logic                    div_by_zero_o
);

    localparam int CNT_W = step_cnt_width(DIV_BIT_NUMB);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_BIT_NUMB - 1);

    // Controller state and step counter.
    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Latched operands. The dividend copy is consumed MSB first by shifting
    // it left once per step, so its top bit is always the next bit to bring
    // into the partial remainder.
    logic [DIV_BIT_NUMB-1:0] dividend_q, dividend_d;
    logic [DIV_BIT_NUMB-1:0] divisor_q, divisor_d;

    // Working registers; they double as the result registers once DONE is
    // reached and hold their values until the next accepted request.
    logic [DIV_BIT_NUMB-1:0] quo_q, quo_d;
    logic [DIV_BIT_NUMB-1:0] rem_q, rem_d;
    logic                    dbz_q, dbz_d;

    // Datapath of a single restoring step.
    logic [DIV_BIT_NUMB:0] shifted_rem;
    logic [DIV_BIT_NUMB:0] adder_b;
    logic [DIV_BIT_NUMB:0] trial;
    logic                  not_borrow;
    logic                  trial_msb_unused;

    // Shift the next dividend bit into the partial remainder. One extra bit
    // is kept because twice the remainder can exceed the operand width.
    assign shifted_rem = {rem_q, dividend_q[DIV_BIT_NUMB-1]};

    // Two's-complement subtraction: shifted_rem + ~{0, divisor} + 1. The
    // inverted operand is zero-extended before inversion so the adder's
    // carry out is exactly the "no borrow" condition shifted_rem >= divisor.
    assign adder_b = ~{1'b0, divisor_q};

    carry_ripple_adder #(
        .CRA_BIT_NUMB (DIV_BIT_NUMB + 1)
    ) u_trial_sub (
        .a_i     (shifted_rem),
        .b_i     (adder_b),
        .carry_i (1'b1),
        .sum_o   (trial),
        .carry_o (not_borrow)
    );

    // On a successful subtraction the difference is below the divisor, so
    // its top bit is always zero and only the lower bits are kept.
    assign trial_msb_unused = trial[DIV_BIT_NUMB];

    // Registers: everything returns to zero and IDLE on reset so that an
    // interrupted division leaves no trace and never completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    // Next-state and datapath control. Every register holds by default;
    // IDLE accepts a request, CALC performs one restoring step per cycle,
    // and DONE always falls back to IDLE after its single cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    dividend_d = dividend_i;
                    divisor_d  = divisor_i;
                    cnt_d      = '0;
                    dbz_d      = 1'b0;
                    if (divisor_i == '0) begin
                        // No steps needed: results are defined directly.
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = '0;
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                // Keep the trial difference when it did not borrow,
                // otherwise restore the shifted remainder.
                if (not_borrow) begin
                    rem_d = trial[DIV_BIT_NUMB-1:0];
                end else begin
                    rem_d = shifted_rem[DIV_BIT_NUMB-1:0];
                end
                quo_d      = {quo_q[DIV_BIT_NUMB-2:0], not_borrow};
                dividend_d = {dividend_q[DIV_BIT_NUMB-2:0], 1'b0};
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and result outputs are decoded straight from the registers.
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider
//
// Purpose:
//   Self-checking bench for restoring_divider with a 4-bit width. A
//   behavioural model predicts busy/done timing and the arithmetic results
//   from / and %, and a compare process checks the DUT against it on every
//   falling clock edge. Directed cases pin the model with hand-computed
//   literal values; latencies are counted in rising edges including the
//   accepting edge itself.
// ---------------------------------------------------------------------------
module tb_restoring_divider;

    localparam int N = 4;

    logic         clk_i      = 1'b0;
    logic         rst_ni     = 1'b1;
    logic         start_i    = 1'b0;
    logic [N-1:0] dividend_i = '0;
    logic [N-1:0] divisor_i  = '0;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] quotient_o;
    logic [N-1:0] remainder_o;
    logic         div_by_zero_o;

    int nCompared   = 0;
    int nMismatched = 0;

    restoring_divider #(
        .DIV_BIT_NUMB (N)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    // 10-unit clock period.
    always #5 clk_i = ~clk_i;

    // Single point where comparisons are counted and failures reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: a request seen while idle yields its results from
    // plain division; completion is signalled N+1 edges after acceptance
    // (1 edge for a zero divisor), counting the accepting edge as the first.
    // Results are only meaningful once complete, or after reset (all zero).
    typedef enum {M_IDLE, M_WORK, M_DONE} mPhase_e;
    mPhase_e      mPhase = M_IDLE;
    int           mLeft  = 0;
    logic [N-1:0] mQ     = '0;
    logic [N-1:0] mR     = '0;
    logic         mZ     = 1'b0;
    bit           mValid = 1'b1;

    // Model update on the same edges the DUT reacts to.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mPhase <= M_IDLE;
            mLeft  <= 0;
            mQ     <= '0;
            mR     <= '0;
            mZ     <= 1'b0;
            mValid <= 1'b1;
        end else begin
            case (mPhase)
                M_IDLE: begin
                    if (start_i) begin
                        if (divisor_i == '0) begin
                            mQ     <= '1;
                            mR     <= dividend_i;
                            mZ     <= 1'b1;
                            mValid <= 1'b1;
                            mPhase <= M_DONE;
                        end else begin
                            mQ     <= dividend_i / divisor_i;
                            mR     <= dividend_i % divisor_i;
                            mZ     <= 1'b0;
                            mValid <= 1'b0;
                            mLeft  <= N - 1;
                            mPhase <= M_WORK;
                        end
                    end
                end
                M_WORK: begin
                    if (mLeft == 0) begin
                        mPhase <= M_DONE;
                        mValid <= 1'b1;
                    end else begin
                        mLeft <= mLeft - 1;
                    end
                end
                default: begin
                    mPhase <= M_IDLE;
                end
            endcase
        end
    end

    // Compare process: status every cycle, results whenever they are valid.
    always @(negedge clk_i) begin
        checkOutput("busy", busy_o, mPhase != M_IDLE);
        checkOutput("done", done_o, mPhase == M_DONE);
        if (mValid) begin
            checkOutput("quotient", quotient_o, mQ);
            checkOutput("remainder", remainder_o, mR);
            checkOutput("div_by_zero", div_by_zero_o, mZ);
        end
    end

    // Wait (bounded) until the divider is idle, then present one request
    // for exactly one rising edge. Returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
        int guard = 0;
        while (busy_o && guard < 40) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (busy_o) checkOutput("idle_timeout", busy_o, 0);
        dividend_i = dvd;
        divisor_i  = dvs;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Count rising edges (accepting edge = 1) until done_o is seen, bounded.
    task automatic awaitDone(output int lat);
        lat = 1;
        while (!done_o && lat < 40) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    // One directed division with literal expectations.
    task automatic runCase(input string name, input logic [N-1:0] dvd,
                           input logic [N-1:0] dvs, input logic [N-1:0] expQ,
                           input logic [N-1:0] expR, input logic expZ,
                           input int expLat);
        int lat;
        applyStimulus(dvd, dvs);
        awaitDone(lat);
        checkOutput({name, "_latency"}, lat, expLat);
        checkOutput({name, "_q"}, quotient_o, expQ);
        checkOutput({name, "_r"}, remainder_o, expR);
        checkOutput({name, "_dbz"}, div_by_zero_o, expZ);
        @(posedge clk_i);
        #1;
    endtask

    // Global time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones;
        int busyDrop;
        int lat;
        logic [N-1:0] gotQ;
        logic [N-1:0] gotR;
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;

        // Reset and its output values.
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_q", quotient_o, 0);
        checkOutput("rst_r", remainder_o, 0);
        checkOutput("rst_dbz", div_by_zero_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Directed arithmetic cases.
        runCase("d13_4",  4'd13, 4'd4,  4'b0011, 4'b0001, 1'b0, N + 1);
        runCase("d15_1",  4'd15, 4'd1,  4'b1111, 4'b0000, 1'b0, N + 1);
        runCase("d3_7",   4'd3,  4'd7,  4'b0000, 4'b0011, 1'b0, N + 1);
        runCase("d9_0",   4'd9,  4'd0,  4'b1111, 4'b1001, 1'b1, 1);
        runCase("d15_15", 4'd15, 4'd15, 4'b0001, 4'b0000, 1'b0, N + 1);
        runCase("d0_5",   4'd0,  4'd5,  4'b0000, 4'b0000, 1'b0, N + 1);
        runCase("d13_4b", 4'd13, 4'd4,  4'b0011, 4'b0001, 1'b0, N + 1);

        // Start pulse with other operands in the middle of a calculation.
        applyStimulus(4'd14, 4'd3);
        @(posedge clk_i);
        #1;
        dividend_i = 4'd2;
        divisor_i  = 4'd1;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        dones    = 0;
        busyDrop = 0;
        gotQ     = '0;
        gotR     = '0;
        for (int k = 0; k < 10; k++) begin
            if (dones == 0 && !busy_o) busyDrop++;
            if (done_o) begin
                dones++;
                gotQ = quotient_o;
                gotR = remainder_o;
            end
            @(posedge clk_i);
            #1;
        end
        checkOutput("midstart_dones", dones, 1);
        checkOutput("midstart_busy_drops", busyDrop, 0);
        checkOutput("midstart_q", gotQ, 4'b0100);
        checkOutput("midstart_r", gotR, 4'b0010);

        // Reset in the third CALC cycle, then an immediate new request.
        applyStimulus(4'd13, 4'd5);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_done", done_o, 0);
        checkOutput("abort_q", quotient_o, 0);
        checkOutput("abort_r", remainder_o, 0);
        checkOutput("abort_dbz", div_by_zero_o, 0);
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        rst_ni     = 1'b1;
        dividend_i = 4'd10;
        divisor_i  = 4'd3;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        awaitDone(lat);
        checkOutput("post_rst_latency", lat, N + 1);
        checkOutput("post_rst_q", quotient_o, 4'b0011);
        checkOutput("post_rst_r", remainder_o, 4'b0001);
        @(posedge clk_i);
        #1;

        // start_i held high: a new request is taken on the first idle edge.
        dividend_i = 4'd6;
        divisor_i  = 4'd2;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        dividend_i = 4'd7;
        divisor_i  = 4'd2;
        dones      = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                dones++;
                gotQ = quotient_o;
                gotR = remainder_o;
            end
        end
        start_i = 1'b0;
        checkOutput("held_dones", dones, 2);
        checkOutput("held_q", gotQ, 4'b0011);
        checkOutput("held_r", gotR, 4'b0001);

        // Random operand pairs; results come from the model, zero divisors
        // are forced in about one case out of eight.
        for (int i = 0; i < 200; i++) begin
            dvd = N'($urandom_range(0, 15));
            dvs = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 15));
            applyStimulus(dvd, dvs);
            awaitDone(lat);
            checkOutput("rand_latency", lat, (dvs == '0) ? 1 : N + 1);
            @(posedge clk_i);
            #1;
        end

        repeat (3) @(posedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
